// File: rtl/fixed_p_std_div_iter.sv
// fixed_p_std_div_iter: multi-cycle unsigned fixed-point divider.
// Restoring radix-2 long division of {left, fract_width'b0} by right,
// one quotient bit per cycle under a go/done handshake. Produces a
// saturated quotient, the integer remainder, and overflow/div-by-zero flags.
// Optional feature: define FIXED_P_DIV_ROUND_EN for round-half-up of the
// quotient (adds one ROUND state, latency N+2 instead of N+1).
module fixed_p_std_div_iter #(
   parameter int width       = 32,
   parameter int int_width   = 8,
   parameter int fract_width = 24
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             go,
   input  logic [width-1:0] left,
   input  logic [width-1:0] right,
   output logic [width-1:0] out,
   output logic [width-1:0] out_remainder,
   output logic             overflow,
   output logic             div_by_zero,
   output logic             done
);

   // Extended dividend length = number of iterations.
   localparam int N  = width + fract_width;
   localparam int CW = $clog2(N + 1);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   generate
      if (int_width + fract_width != width) begin : g_param_chk
         $error("fixed_p_std_div_iter: int_width + fract_width must equal width");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY,
      S_ROUND,
      S_DONE
   } state_t;

   state_t           state_q;
   logic [CW-1:0]    cnt_q;
   logic [N-1:0]     dvd_q;     // extended dividend, consumed MSB first
   logic [width-1:0] div_q;     // captured divisor
   logic [width-1:0] rem_q;     // partial remainder, always < div_q
   logic [width-1:0] quo_q;     // low width bits of the quotient
   logic             ovf_q;     // sticky: a 1 was shifted past bit width-1
   logic [width-1:0] out_q;
   logic [width-1:0] orem_q;
   logic             oovf_q;
   logic             dbz_q;
   logic             done_q;

   // One restoring step: shift in the next dividend bit and trial-subtract.
   logic [width:0]   trial;
   logic [width:0]   diff;
   logic             take;
   logic [width-1:0] rem_d;
   logic [width-1:0] quo_d;
   logic             ovf_d;

   // Trial subtraction for the current iteration.
   always_comb begin
      trial = {rem_q, dvd_q[N-1]};
      diff  = trial - {1'b0, div_q};
      take  = (trial >= {1'b0, div_q});
      rem_d = take ? diff[width-1:0] : trial[width-1:0];
      quo_d = {quo_q[width-2:0], take};
      ovf_d = ovf_q | quo_q[width-1];
   end

`ifdef FIXED_P_DIV_ROUND_EN
   logic             rnd_up;
   logic [width:0]   rnd_sum;

   // Round half up: bump the quotient when 2*R >= divisor.
   always_comb begin
      rnd_up  = ({rem_q, 1'b0} >= {1'b0, div_q});
      rnd_sum = {1'b0, quo_q} + {{width{1'b0}}, rnd_up};
   end
`endif

   // Control FSM plus datapath registers and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         dvd_q   <= '0;
         div_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         ovf_q   <= 1'b0;
         out_q   <= '0;
         orem_q  <= '0;
         oovf_q  <= 1'b0;
         dbz_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (go) begin
                  dvd_q   <= {left, {fract_width{1'b0}}};
                  div_q   <= right;
                  rem_q   <= '0;
                  quo_q   <= '0;
                  ovf_q   <= 1'b0;
                  cnt_q   <= '0;
                  out_q   <= '0;
                  orem_q  <= '0;
                  oovf_q  <= 1'b0;
                  dbz_q   <= 1'b0;
                  // A zero divisor skips the iterations entirely.
                  state_q <= (right == '0) ? S_DONE : S_BUSY;
               end
            end
            S_BUSY: begin
               rem_q <= rem_d;
               quo_q <= quo_d;
               ovf_q <= ovf_d;
               dvd_q <= {dvd_q[N-2:0], 1'b0};
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == LAST) begin
`ifdef FIXED_P_DIV_ROUND_EN
                  state_q <= S_ROUND;
`else
                  state_q <= S_DONE;
`endif
               end
            end
`ifdef FIXED_P_DIV_ROUND_EN
            S_ROUND: begin
               // A carry out of the rounded quotient counts as overflow.
               quo_q   <= rnd_sum[width-1:0];
               ovf_q   <= ovf_q | rnd_sum[width];
               state_q <= S_DONE;
            end
`endif
            S_DONE: begin
               done_q <= 1'b1;
               if (div_q == '0) begin
                  // dvd_q was never shifted, so its top bits still hold left.
                  out_q  <= '1;
                  orem_q <= dvd_q[N-1 -: width];
                  oovf_q <= 1'b0;
                  dbz_q  <= 1'b1;
               end else begin
                  out_q  <= ovf_q ? '1 : quo_q;
                  orem_q <= rem_q;
                  oovf_q <= ovf_q;
                  dbz_q  <= 1'b0;
               end
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign out           = out_q;
   assign out_remainder = orem_q;
   assign overflow      = oovf_q;
   assign div_by_zero   = dbz_q;
   assign done          = done_q;

endmodule

// File: tb/tb_fixed_p_std_div_iter.sv
// Testbench for fixed_p_std_div_iter (width=8, int_width=4, fract_width=4).
// Random and directed operands are checked against an arithmetic reference
// model of the division; honours FIXED_P_DIV_ROUND_EN when defined.
module tb_fixed_p_std_div_iter;

   localparam int W  = 8;
   localparam int IW = 4;
   localparam int FW = 4;
   localparam int N  = W + FW;
`ifdef FIXED_P_DIV_ROUND_EN
   localparam int RND = 1;
`else
   localparam int RND = 0;
`endif

   logic         clk = 1'b0;
   logic         rst_n;
   logic         go_s;
   logic [W-1:0] left_s;
   logic [W-1:0] right_s;
   logic [W-1:0] out_s;
   logic [W-1:0] rem_s;
   logic         ovf_s;
   logic         dbz_s;
   logic         done_s;

   int checks = 0;
   int errors = 0;

   fixed_p_std_div_iter #(
      .width       (W),
      .int_width   (IW),
      .fract_width (FW)
   ) dut (
      .clk           (clk),
      .reset         (rst_n),
      .go            (go_s),
      .left          (left_s),
      .right         (right_s),
      .out           (out_s),
      .out_remainder (rem_s),
      .overflow      (ovf_s),
      .div_by_zero   (dbz_s),
      .done          (done_s)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: Q = floor((l * 2^FW) / r), optional half-up, saturate at 2^W.
   function automatic void model(input int l, input int r, output int eo, output int er,
                                 output int eov, output int edz, output int elat);
      longint d, q, rm;
      if (r == 0) begin
         eo = (1 << W) - 1; er = l; eov = 0; edz = 1; elat = 1;
      end else begin
         d  = longint'(l) << FW;
         q  = d / r;
         rm = d % r;
         if (RND != 0 && 2 * rm >= r) q++;
         if (q >= (longint'(1) << W)) begin
            eo = (1 << W) - 1; eov = 1;
         end else begin
            eo = int'(q); eov = 0;
         end
         er = int'(rm); edz = 0; elat = N + 1 + RND;
      end
   endfunction

   // Called between edges with the DUT idle (or in its done cycle).
   task automatic do_op(input int l, input int r, input bit hold);
      int eo, er, eov, edz, elat, lat;
      model(l, r, eo, er, eov, edz, elat);
      left_s  = l[W-1:0];
      right_s = r[W-1:0];
      go_s    = 1'b1;
      @(posedge clk); #1;
      chk("clr_out", {24'b0, out_s}, 0);
      chk("clr_done", {31'b0, done_s}, 0);
      if (!hold) go_s = 1'b0;
      left_s  = W'($urandom);
      right_s = W'($urandom);
      lat = 0;
      while (!done_s && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("latency", lat, elat);
      chk("out", {24'b0, out_s}, eo);
      chk("rem", {24'b0, rem_s}, er);
      chk("ovf", {31'b0, ovf_s}, eov);
      chk("dbz", {31'b0, dbz_s}, edz);
   endtask

   initial begin
      int nd, l, r;
      rst_n = 1'b0; go_s = 1'b0; left_s = '0; right_s = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out", {24'b0, out_s}, 0);
      chk("rst_rem", {24'b0, rem_s}, 0);
      chk("rst_ovf", {31'b0, ovf_s}, 0);
      chk("rst_dbz", {31'b0, dbz_s}, 0);
      chk("rst_done", {31'b0, done_s}, 0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed cases, including the saturation and zero-divisor corners.
      do_op(8'h30, 8'h20, 0);
      @(posedge clk); #1;
      chk("done_pulse", {31'b0, done_s}, 0);
      chk("hold_out", {24'b0, out_s}, 8'h18);
      do_op(8'h20, 8'h30, 0);
      do_op(8'hF0, 8'h01, 0);
      do_op(8'h55, 8'h00, 0);
      @(posedge clk); #1;
      chk("done_pulse_dz", {31'b0, done_s}, 0);
      do_op(8'hFF, 8'hFF, 0);
      do_op(8'h00, 8'h07, 0);
      do_op(8'h00, 8'h00, 0);
      do_op(8'h0F, 8'hFF, 0);

      // Async reset while results are held: outputs drop immediately.
      do_op(8'h20, 8'h30, 0);
      rst_n = 1'b0; #1;
      chk("arst_out", {24'b0, out_s}, 0);
      chk("arst_rem", {24'b0, rem_s}, 0);
      chk("arst_done", {31'b0, done_s}, 0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      // Reset at iteration 5: abort with no done pulse, then a clean op.
      left_s = 8'h30; right_s = 8'h20; go_s = 1'b1;
      @(posedge clk); #1;
      go_s = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rst_n = 1'b0; #1;
      chk("mid_out", {24'b0, out_s}, 0);
      chk("mid_done", {31'b0, done_s}, 0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      nd = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (done_s) nd++;
      end
      chk("mid_nodone", nd, 0);
      do_op(8'h30, 8'h20, 0);

      // Random single operations with idle gaps.
      for (int i = 0; i < 150; i++) begin
         case ($urandom_range(9))
            0:       r = 0;
            1, 2, 3: r = int'($urandom_range(15, 1));
            default: r = int'($urandom_range(255));
         endcase
         l = int'($urandom_range(255));
         do_op(l, r, 0);
         repeat ($urandom_range(2)) begin
            @(posedge clk); #1;
         end
      end

      // go held high: each done cycle is followed straight by the next start.
      for (int i = 0; i < 30; i++) begin
         l = int'($urandom_range(255));
         r = (i % 7 == 3) ? 0 : int'($urandom_range(255));
         do_op(l, r, 1);
      end
      go_s = 1'b0;
      repeat (3) @(posedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
